// File: rtl/shortest_path_fw.sv
// All-pairs shortest-path engine (Floyd-Warshall) over external single-port M/L/P SRAMs.
// Latency: Go to Done = (N^2+1) + N(2N-1) + 5N(N-1)^2 cycles (225 for N=4).
// Backpressure: none; the SRAMs respond in fixed time, and Go is ignored while a run is active.
module shortest_path_fw #(
    parameter int N_LOG2  = 4,
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 2 * N_LOG2,
    parameter int PRED_EN = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Go,
    input  logic               Hop_Mode,
    input  logic [D_WIDTH-1:0] M_In,
    input  logic [D_WIDTH-1:0] L_In,
    output logic [D_WIDTH-1:0] L_Out,
    output logic [D_WIDTH-1:0] P_Out,
    output logic [A_WIDTH-1:0] M_Addr,
    output logic [A_WIDTH-1:0] L_Addr,
    output logic [A_WIDTH-1:0] P_Addr,
    output logic               M_En,
    output logic               M_Rw,
    output logic               L_En,
    output logic               L_Rw,
    output logic               P_En,
    output logic               P_Rw,
    output logic               Done
);

    localparam int N  = 1 << N_LOG2;
    localparam int NN = N * N;
    localparam int CW = A_WIDTH + 1;

    // "No path" distance and "no intermediate node" marker share the all-ones code.
    localparam logic [D_WIDTH-1:0] INF  = '1;
    localparam logic [D_WIDTH-1:0] NONE = '1;
    localparam logic [N_LOG2-1:0]  NMAX = '1;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_INIT  = 4'd1;
    localparam logic [3:0] S_RD_IK = 4'd2;
    localparam logic [3:0] S_RD_KJ = 4'd3;
    localparam logic [3:0] S_RD_IJ = 4'd4;
    localparam logic [3:0] S_CMP   = 4'd5;
    localparam logic [3:0] S_WR    = 4'd6;
    localparam logic [3:0] S_ADV   = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    logic [3:0]         state;
    logic [N_LOG2-1:0]  k_idx;
    logic [N_LOG2-1:0]  i_idx;
    logic [N_LOG2-1:0]  j_idx;
    logic [CW-1:0]      init_cnt;
    logic               hop_q;
    logic [D_WIDTH-1:0] ik_q;
    logic [D_WIDTH-1:0] kj_q;
    logic [D_WIDTH-1:0] sum_q;
    logic               upd_q;

    logic [N_LOG2-1:0]  k_nxt;
    logic [N_LOG2-1:0]  i_nxt;
    logic [N_LOG2-1:0]  j_nxt;
    logic               last_trip;
    logic               skip_nxt;

    logic               init_last;
    logic               init_rd;
    logic               init_wr;
    logic [A_WIDTH-1:0] init_wr_addr;
    logic               init_diag;
    logic [D_WIDTH-1:0] init_val;

    logic [D_WIDTH:0]   sum_c;
    logic               upd_c;
    logic [D_WIDTH-1:0] k_ext;

    // Next (k,i,j) in k-outer / i-middle / j-inner order, plus end-of-run and skip detection.
    always_comb begin
        j_nxt = j_idx + N_LOG2'(1);
        i_nxt = i_idx;
        k_nxt = k_idx;
        if (j_idx == NMAX) begin
            i_nxt = i_idx + N_LOG2'(1);
            if (i_idx == NMAX) begin
                k_nxt = k_idx + N_LOG2'(1);
            end
        end
        last_trip = (k_idx == NMAX) && (i_idx == NMAX) && (j_idx == NMAX);
        skip_nxt  = (i_nxt == k_nxt) || (j_nxt == k_nxt);
    end

    // INIT pipeline: cycle c reads M[c] and writes entry c-1 from the data returned for it.
    always_comb begin
        init_last    = (init_cnt == CW'(NN));
        init_rd      = (init_cnt < CW'(NN));
        init_wr      = (init_cnt != '0);
        init_wr_addr = init_cnt[A_WIDTH-1:0] - A_WIDTH'(1);
        init_diag    = (init_wr_addr[2*N_LOG2-1:N_LOG2] == init_wr_addr[N_LOG2-1:0]);
        if (init_diag) begin
            init_val = '0;
        end else if (M_In == INF) begin
            init_val = INF;
        end else if (hop_q) begin
            init_val = D_WIDTH'(1);
        end else begin
            init_val = M_In;
        end
    end

    // Relaxation: one extra sum bit keeps overflow visible, so saturation is just "sum < INF".
    always_comb begin
        sum_c = {1'b0, ik_q} + {1'b0, kj_q};
        upd_c = (ik_q != INF) && (kj_q != INF) &&
                (sum_c < {1'b0, INF}) && (sum_c < {1'b0, L_In});
        k_ext = '0;
        k_ext[N_LOG2-1:0] = k_idx;
    end

    // Control FSM, loop counters and pipeline captures.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_IDLE;
            k_idx    <= '0;
            i_idx    <= '0;
            j_idx    <= '0;
            init_cnt <= '0;
            hop_q    <= 1'b0;
            ik_q     <= '0;
            kj_q     <= '0;
            sum_q    <= '0;
            upd_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Go) begin
                        state    <= S_INIT;
                        init_cnt <= '0;
                        hop_q    <= Hop_Mode;
                        k_idx    <= '0;
                        i_idx    <= '0;
                        j_idx    <= '0;
                    end
                end
                S_INIT: begin
                    if (init_last) begin
                        // The first triple (0,0,0) has i==k, so it is always a skip.
                        state <= S_ADV;
                    end else begin
                        init_cnt <= init_cnt + CW'(1);
                    end
                end
                S_RD_IK: begin
                    state <= S_RD_KJ;
                end
                S_RD_KJ: begin
                    ik_q  <= L_In;
                    state <= S_RD_IJ;
                end
                S_RD_IJ: begin
                    kj_q  <= L_In;
                    state <= S_CMP;
                end
                S_CMP: begin
                    sum_q <= sum_c[D_WIDTH-1:0];
                    upd_q <= upd_c;
                    state <= S_WR;
                end
                S_WR, S_ADV: begin
                    if (last_trip) begin
                        state <= S_DONE;
                    end else begin
                        k_idx <= k_nxt;
                        i_idx <= i_nxt;
                        j_idx <= j_nxt;
                        state <= skip_nxt ? S_ADV : S_RD_IK;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port decode; every control and data output idles at zero outside its state.
    always_comb begin
        M_En   = 1'b0;
        M_Addr = '0;
        L_En   = 1'b0;
        L_Rw   = 1'b0;
        L_Addr = '0;
        L_Out  = '0;
        P_En   = 1'b0;
        P_Rw   = 1'b0;
        P_Addr = '0;
        P_Out  = '0;
        case (state)
            S_INIT: begin
                if (init_rd) begin
                    M_En   = 1'b1;
                    M_Addr = init_cnt[A_WIDTH-1:0];
                end
                if (init_wr) begin
                    L_En   = 1'b1;
                    L_Rw   = 1'b1;
                    L_Addr = init_wr_addr;
                    L_Out  = init_val;
                    if (PRED_EN != 0) begin
                        P_En   = 1'b1;
                        P_Rw   = 1'b1;
                        P_Addr = init_wr_addr;
                        P_Out  = NONE;
                    end
                end
            end
            S_RD_IK: begin
                L_En   = 1'b1;
                L_Addr = A_WIDTH'({i_idx, k_idx});
            end
            S_RD_KJ: begin
                L_En   = 1'b1;
                L_Addr = A_WIDTH'({k_idx, j_idx});
            end
            S_RD_IJ: begin
                L_En   = 1'b1;
                L_Addr = A_WIDTH'({i_idx, j_idx});
            end
            S_WR: begin
                if (upd_q) begin
                    L_En   = 1'b1;
                    L_Rw   = 1'b1;
                    L_Addr = A_WIDTH'({i_idx, j_idx});
                    L_Out  = sum_q;
                    if (PRED_EN != 0) begin
                        P_En   = 1'b1;
                        P_Rw   = 1'b1;
                        P_Addr = A_WIDTH'({i_idx, j_idx});
                        P_Out  = k_ext;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // M is read-only to this engine.
    assign M_Rw = 1'b0;
    assign Done = (state == S_DONE);

endmodule

// File: tb/tb_shortest_path_fw.sv
// Scoreboard bench for shortest_path_fw with N=4, two instances (predecessor output on/off).
// Stimulus pushes hand-computed expectations per run; a monitor checks them when Done rises.
// SRAMs are modelled here with one-cycle read latency.
module tb_shortest_path_fw;

    localparam int NL = 2;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int INF = 255;

    localparam int K_L    = 0;
    localparam int K_P    = 1;
    localparam int K_LAT  = 2;
    localparam int K_L2   = 3;
    localparam int K_BDON = 4;

    logic clk = 1'b0;
    logic rst, go, hop;

    logic [DW-1:0] a_m_in, a_l_in, a_l_out, a_p_out;
    logic [AW-1:0] a_m_addr, a_l_addr, a_p_addr;
    logic          a_m_en, a_m_rw, a_l_en, a_l_rw, a_p_en, a_p_rw, a_done;

    logic [DW-1:0] b_m_in, b_l_in, b_l_out, b_p_out;
    logic [AW-1:0] b_m_addr, b_l_addr, b_p_addr;
    logic          b_m_en, b_m_rw, b_l_en, b_l_rw, b_p_en, b_p_rw, b_done;

    logic [DW-1:0] m_mem  [16];
    logic [DW-1:0] l_mem  [16];
    logic [DW-1:0] p_mem  [16];
    logic [DW-1:0] l2_mem [16];
    logic [DW-1:0] p2_mem [16];

    typedef struct {
        int run;
        int kind;
        int addr;
        int val;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int go_cyc  = 0;
    int exp_run = 0;
    int mon_run = 0;
    int p2_seen = 0;
    logic done_prev = 1'b0;

    shortest_path_fw #(.N_LOG2(NL), .D_WIDTH(DW), .A_WIDTH(AW), .PRED_EN(1)) u_dut (
        .Clk(clk), .Rst(rst), .Go(go), .Hop_Mode(hop),
        .M_In(a_m_in), .L_In(a_l_in), .L_Out(a_l_out), .P_Out(a_p_out),
        .M_Addr(a_m_addr), .L_Addr(a_l_addr), .P_Addr(a_p_addr),
        .M_En(a_m_en), .M_Rw(a_m_rw), .L_En(a_l_en), .L_Rw(a_l_rw),
        .P_En(a_p_en), .P_Rw(a_p_rw), .Done(a_done)
    );

    shortest_path_fw #(.N_LOG2(NL), .D_WIDTH(DW), .A_WIDTH(AW), .PRED_EN(0)) u_dut_np (
        .Clk(clk), .Rst(rst), .Go(go), .Hop_Mode(hop),
        .M_In(b_m_in), .L_In(b_l_in), .L_Out(b_l_out), .P_Out(b_p_out),
        .M_Addr(b_m_addr), .L_Addr(b_l_addr), .P_Addr(b_p_addr),
        .M_En(b_m_en), .M_Rw(b_m_rw), .L_En(b_l_en), .L_Rw(b_l_rw),
        .P_En(b_p_en), .P_Rw(b_p_rw), .Done(b_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models for both instances (M contents shared, read ports separate).
    always @(posedge clk) begin
        if (a_m_en && !a_m_rw) a_m_in <= m_mem[a_m_addr];
        if (a_l_en) begin
            if (a_l_rw) l_mem[a_l_addr] <= a_l_out;
            else        a_l_in <= l_mem[a_l_addr];
        end
        if (a_p_en && a_p_rw) p_mem[a_p_addr] <= a_p_out;
        if (b_m_en && !b_m_rw) b_m_in <= m_mem[b_m_addr];
        if (b_l_en) begin
            if (b_l_rw) l2_mem[b_l_addr] <= b_l_out;
            else        b_l_in <= l2_mem[b_l_addr];
        end
        if (b_p_en && b_p_rw) p2_mem[b_p_addr] <= b_p_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int i, input int j, input int val);
        exp_t x;
        x.run  = exp_run;
        x.kind = kind;
        x.addr = i * 4 + j;
        x.val  = val;
        sb.push_back(x);
    endtask

    task automatic clear_m();
        for (int a = 0; a < 16; a++) m_mem[a] = 8'(INF);
    endtask

    task automatic set_edge(input int i, input int j, input int w);
        m_mem[i * 4 + j] = 8'(w);
    endtask

    task automatic load_chain();
        clear_m();
        set_edge(0, 1, 3);
        set_edge(1, 2, 4);
        set_edge(2, 3, 5);
    endtask

    // Called at #1 after a posedge; returns at #1 after the edge that samples Go.
    task automatic start_run(input logic h);
        hop = h;
        go  = 1'b1;
        @(posedge clk);
        #1;
        go_cyc = cyc;
        go  = 1'b0;
        hop = 1'b0;
    endtask

    task automatic wait_done();
        int prev;
        prev = mon_run;
        for (int c = 0; c < 2000 && mon_run == prev; c++) @(posedge clk);
        #1;
        check("run_complete", mon_run, prev + 1);
        exp_run++;
    endtask

    task automatic push_chain_weighted();
        push(K_L, 0, 3, 12);  push(K_P, 0, 3, 2);
        push(K_L, 0, 2, 7);   push(K_P, 0, 2, 1);
        push(K_L, 1, 3, 9);   push(K_P, 1, 3, 2);
        push(K_L, 3, 0, 255); push(K_P, 3, 0, 255);
        push(K_L, 0, 1, 3);   push(K_P, 0, 1, 255);
        for (int d = 0; d < 4; d++) push(K_L, d, d, 0);
        push(K_LAT, 0, 0, 225);
        push(K_L2, 0, 3, 12);
        push(K_L2, 1, 3, 9);
        push(K_BDON, 0, 0, 1);
    endtask

    // Monitor: on each rising Done, pop and compare all expectations of that run.
    initial begin
        forever begin
            @(negedge clk);
            if (b_p_en) p2_seen++;
            if (a_done === 1'b1 && done_prev !== 1'b1) begin
                while (sb.size() > 0 && sb[0].run == mon_run) begin
                    e = sb.pop_front();
                    case (e.kind)
                        K_L:    check($sformatf("run%0d_L[%0d][%0d]", e.run, e.addr / 4, e.addr % 4),
                                      l_mem[e.addr], e.val);
                        K_P:    check($sformatf("run%0d_P[%0d][%0d]", e.run, e.addr / 4, e.addr % 4),
                                      p_mem[e.addr], e.val);
                        K_LAT:  check($sformatf("run%0d_latency", e.run), cyc - go_cyc, e.val);
                        K_L2:   check($sformatf("run%0d_nopred_L[%0d][%0d]", e.run, e.addr / 4, e.addr % 4),
                                      l2_mem[e.addr], e.val);
                        default: check($sformatf("run%0d_nopred_done", e.run), b_done, e.val);
                    endcase
                end
                mon_run++;
            end
            done_prev = a_done;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        go  = 1'b1;
        hop = 1'b0;
        clear_m();

        // Reset, with Go held high throughout.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {a_m_en, a_m_rw, a_l_en, a_l_rw, a_p_en, a_p_rw, a_done}, 0);
        check("rst_addr", {a_m_addr, a_l_addr, a_p_addr}, 0);
        check("rst_data", {a_l_out, a_p_out}, 0);
        rst = 1'b0;
        go  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst_m_en", a_m_en, 0);
        check("idle_after_rst_done", a_done, 0);

        // Run 0: weighted chain.
        load_chain();
        push_chain_weighted();
        start_run(1'b0);
        check("done_clear_after_go", a_done, 0);
        wait_done();

        // Run 1: same chain, hop count.
        push(K_L, 0, 3, 3);   push(K_P, 0, 3, 2);
        push(K_L, 0, 2, 2);
        push(K_L, 1, 3, 2);
        push(K_L, 3, 0, 255);
        push(K_LAT, 0, 0, 225);
        start_run(1'b1);
        wait_done();

        // Run 2: saturation, including a sum landing exactly on INF.
        clear_m();
        set_edge(0, 1, 200);
        set_edge(1, 2, 100);
        set_edge(3, 1, 155);
        push(K_L, 0, 2, 255); push(K_P, 0, 2, 255);
        push(K_L, 0, 1, 200);
        push(K_L, 3, 2, 255); push(K_P, 3, 2, 255);
        push(K_L, 3, 1, 155);
        start_run(1'b0);
        wait_done();

        // Run 3: tie keeps the direct edge; stray Go pulses mid-run are ignored.
        clear_m();
        set_edge(0, 2, 5);
        set_edge(0, 1, 2);
        set_edge(1, 2, 3);
        push(K_L, 0, 2, 5);   push(K_P, 0, 2, 255);
        push(K_L, 0, 1, 2);
        push(K_L, 1, 2, 3);
        push(K_LAT, 0, 0, 225);
        start_run(1'b0);
        repeat (40) @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        repeat (60) @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        wait_done();

        // Run 4: reset mid-run, then a fresh run must match an uninterrupted one.
        load_chain();
        start_run(1'b0);
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_rst_done", a_done, 0);
        check("midrun_rst_l_en", a_l_en, 0);
        push_chain_weighted();
        start_run(1'b0);
        wait_done();

        check("nopred_p_en_never", p2_seen, 0);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
